// File: rtl/seq_gen_param.sv
// Parametrised serial sequence generator: streams a captured pattern MSB-first.
// Optional LFSR mode (mode 11) is built only when SEQ_GEN_LFSR_EN is defined.
module seq_gen_param #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
`ifdef SEQ_GEN_LFSR_EN
   ,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 'hB400
`endif
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stop,
   input  logic [WIDTH-1:0]             pattern,
   input  logic [$clog2(WIDTH+1)-1:0]   len,
   input  logic [1:0]                   mode,
   input  logic [CNT_W-1:0]             repeat_cnt,
   output logic                         data_out,
   output logic                         valid,
   output logic                         busy,
   output logic                         done
);

   localparam int LW = $clog2(WIDTH+1);
   localparam int IW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_pat;
   logic [IW-1:0]      r_idx;
   logic [IW-1:0]      r_last;
   logic [1:0]         r_mode;
   logic [CNT_W-1:0]   r_rep;

   logic [LW-1:0]      w_len;
   logic [IW-1:0]      w_last;
   logic               w_accept;
   logic               w_eop;
   logic               w_reload;
   logic               w_lfsr_mode;
   logic               w_bit;

   // Out-of-range lengths fall back to the full pattern width
   assign w_len = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;
   assign w_last   = IW'(w_len - LW'(1));
   assign w_accept = (r_state == S_IDLE) && start && !stop;
   assign w_eop    = (r_idx == '0);
   assign w_reload = (r_mode == 2'b10) ||
                     ((r_mode == 2'b01) && (r_rep != '0));

`ifdef SEQ_GEN_LFSR_EN
   logic [WIDTH-1:0]   r_lfsr;

   assign w_lfsr_mode = (r_mode == 2'b11);
   assign w_bit = w_lfsr_mode ? r_lfsr[WIDTH-1] : r_pat[r_idx];
`else
   assign w_lfsr_mode = 1'b0;
   assign w_bit = r_pat[r_idx];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            if (stop) begin
               w_next = S_IDLE;
            end else if (!w_lfsr_mode && w_eop) begin
               w_next = w_reload ? S_SHIFT : S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_comb begin
      valid    = (r_state == S_SHIFT);
      busy     = (r_state != S_IDLE);
      done     = (r_state == S_DONE);
      data_out = valid & w_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat  <= '0;
         r_idx  <= '0;
         r_last <= '0;
         r_mode <= '0;
         r_rep  <= '0;
`ifdef SEQ_GEN_LFSR_EN
         r_lfsr <= '0;
`endif
      end else if (w_accept) begin
         r_pat  <= pattern;
         r_idx  <= w_last;
         r_last <= w_last;
         r_mode <= mode;
         r_rep  <= repeat_cnt;
`ifdef SEQ_GEN_LFSR_EN
         r_lfsr <= (pattern == '0) ? '1 : pattern;
`endif
      end else if (r_state == S_SHIFT && !stop) begin
         if (w_eop) begin
            r_idx <= r_last;
            if (r_mode == 2'b01 && r_rep != '0) begin
               r_rep <= r_rep - 1'b1;
            end
         end else begin
            r_idx <= r_idx - 1'b1;
         end
`ifdef SEQ_GEN_LFSR_EN
         if (w_lfsr_mode) begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], ^(r_lfsr & LFSR_TAPS)};
         end
`endif
      end
   end

endmodule

// File: tb/tb_seq_gen_param.sv
// Directed self-checking bench for seq_gen_param.
// Covers one-shot, repeat, continuous/stop, busy protection, reset and mode 11.
module tb_seq_gen_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic [1:0]  mode;
   logic [7:0]  repeat_cnt;
   logic        data_out;
   logic        valid;
   logic        busy;
   logic        done;

   int          total = 0;
   int          bad = 0;
   int          dc;
   logic [15:0] lf;
   logic [8:0]  e9;
   logic [3:0]  e4;
   logic [15:0] e16;

   seq_gen_param dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .pattern    (pattern),
      .len        (len),
      .mode       (mode),
      .repeat_cnt (repeat_cnt),
      .data_out   (data_out),
      .valid      (valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 00F0, len 8: bits 11110000; optional start re-pulse on bit rp
   task automatic run_oneshot(input logic [1:0] m, input int rp);
      logic [7:0] exp;
      exp = 8'hF0;
      pattern = 16'h00F0;
      len = 5'd8;
      mode = m;
      repeat_cnt = 8'd0;
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         start = (i + 1 == rp);
         chk("os_data", data_out, exp[7-i]);
         chk("os_valid", valid, 1);
         chk("os_done_low", done, 0);
      end
      tick();
      start = 1'b0;
      chk("os_done", done, 1);
      chk("os_valid_off", valid, 0);
      chk("os_busy_done", busy, 1);
      chk("os_data_off", data_out, 0);
      tick();
      chk("os_busy_end", busy, 0);
      chk("os_done_end", done, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      pattern = '0;
      len = '0;
      mode = '0;
      repeat_cnt = '0;
      tick();
      tick();
      chk("rst_data", data_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // T1 one-shot
      run_oneshot(2'b00, 0);

      // T4 start re-pulse on bit 3, then start+stop in IDLE
      run_oneshot(2'b00, 3);
      start = 1'b1;
      stop = 1'b1;
      tick();
      chk("ss_busy1", busy, 0);
      tick();
      chk("ss_busy2", busy, 0);
      chk("ss_valid", valid, 0);
      start = 1'b0;
      stop = 1'b0;
      tick();

      // T2 repeat: 101 x3
      pattern = 16'h0005;
      len = 5'd3;
      mode = 2'b01;
      repeat_cnt = 8'd2;
      start = 1'b1;
      e9 = 9'b101101101;
      dc = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         start = 1'b0;
         chk("rep_data", data_out, e9[8-i]);
         chk("rep_valid", valid, 1);
         dc += int'(done);
      end
      tick();
      chk("rep_done", done, 1);
      chk("rep_valid_off", valid, 0);
      dc += int'(done);
      tick();
      dc += int'(done);
      chk("rep_busy_end", busy, 0);
      chk("rep_done_cnt", dc, 1);

      // T3 continuous then stop; upper pattern bits must be ignored
      pattern = 16'hA00A;
      len = 5'd4;
      mode = 2'b10;
      repeat_cnt = 8'd0;
      start = 1'b1;
      e4 = 4'hA;
      dc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         start = 1'b0;
         chk("cont_data", data_out, e4[3-(i%4)]);
         chk("cont_valid", valid, 1);
         dc += int'(done);
         if (i == 9) stop = 1'b1;
      end
      tick();
      chk("stop_valid", valid, 0);
      chk("stop_busy", busy, 0);
      chk("stop_data", data_out, 0);
      dc += int'(done);
      stop = 1'b0;
      tick();
      chk("stop_idle", busy, 0);
      dc += int'(done);
      chk("stop_no_done", dc, 0);

      // len=1 with start held through DONE: 1-cycle gap, fresh capture
      pattern = 16'h0001;
      len = 5'd1;
      mode = 2'b00;
      start = 1'b1;
      tick();
      chk("l1_data", data_out, 1);
      chk("l1_valid", valid, 1);
      pattern = 16'h0000;
      tick();
      chk("l1_done", done, 1);
      tick();
      chk("l1_gap", busy, 0);
      tick();
      chk("l1_restart", valid, 1);
      chk("l1_recapture", data_out, 0);
      start = 1'b0;
      tick();
      chk("l1_done2", done, 1);
      tick();
      chk("l1_idle", busy, 0);

      // len=0 means full width
      pattern = 16'h8001;
      len = 5'd0;
      start = 1'b1;
      e16 = 16'h8001;
      for (int i = 0; i < 16; i++) begin
         tick();
         start = 1'b0;
         chk("l0_data", data_out, e16[15-i]);
         chk("l0_valid", valid, 1);
      end
      tick();
      chk("l0_done", done, 1);
      tick();

      // T5 async reset mid-run
      pattern = 16'h00F0;
      len = 5'd8;
      mode = 2'b00;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         start = 1'b0;
      end
      chk("r5_valid_pre", valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r5_valid", valid, 0);
      chk("r5_busy", busy, 0);
      chk("r5_data", data_out, 0);
      chk("r5_done", done, 0);
      tick();
      tick();
      chk("r5_busy_hold", busy, 0);
      rst_n = 1'b1;
      run_oneshot(2'b00, 0);

`ifdef SEQ_GEN_LFSR_EN
      // T6 LFSR with zero seed -> all-ones
      pattern = 16'h0000;
      len = 5'd8;
      mode = 2'b11;
      start = 1'b1;
      lf = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         tick();
         start = 1'b0;
         chk("lfsr_data", data_out, lf[15]);
         chk("lfsr_valid", valid, 1);
         lf = {lf[14:0], ^(lf & 16'hB400)};
      end
      stop = 1'b1;
      tick();
      chk("lfsr_stop", busy, 0);
      stop = 1'b0;
`else
      // mode 11 without LFSR behaves as one-shot
      lf = 16'h0000;
      run_oneshot(2'b11, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
